// File: rtl/pc_gen_if.sv
// Fetch/redirect bundle between the PC generator and its neighbours.
// master: the PC generator side; slave: the fetch/redirect side.
interface pc_gen_if #(
  parameter int ADDR_W    = 32,
  parameter int NUM_REDIR = 3,
  parameter int CNT_W     = 16
);
  logic                        stall_i;
  logic [NUM_REDIR-1:0]        redir_valid_i;
  logic [NUM_REDIR*ADDR_W-1:0] redir_addr_i;
  logic                        fetch_ready_i;
  logic [ADDR_W-1:0]           pc_o;
  logic                        fetch_valid_o;
  logic                        ce_o;
  logic                        hold_o;
  logic [CNT_W-1:0]            redir_cnt_o;

  modport master (
    input  stall_i, redir_valid_i, redir_addr_i, fetch_ready_i,
    output pc_o, fetch_valid_o, ce_o, hold_o, redir_cnt_o
  );

  modport slave (
    output stall_i, redir_valid_i, redir_addr_i, fetch_ready_i,
    input  pc_o, fetch_valid_o, ce_o, hold_o, redir_cnt_o
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: sequential fetch, prioritised redirects,
// redirects seen during a stall are parked and applied when it clears.
module pc_gen #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter int                INST_BYTES = 4,
  parameter int                NUM_REDIR  = 3,
  parameter int                ALIGN_LSB  = 1,
  parameter int                CNT_W      = 16
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.master bus
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << ALIGN_LSB) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] RESET_PC   = RESET_VEC & ALIGN_MASK;
  localparam logic [ADDR_W-1:0] INC        = ADDR_W'(INST_BYTES);

  typedef enum logic [1:0] {OFF, RUN, HOLD} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] pend, pend_nxt;
  logic [ADDR_W-1:0] tgt;
  logic              any;
  logic              apply;
  logic [CNT_W-1:0]  cnt;

  // Fixed priority: scan high to low so the lowest asserted index wins.
  always_comb begin
    tgt = '0;
    for (int k = NUM_REDIR - 1; k >= 0; k--) begin
      if (bus.redir_valid_i[k]) tgt = bus.redir_addr_i[k*ADDR_W +: ADDR_W] & ALIGN_MASK;
    end
  end

  assign any = |bus.redir_valid_i;

  // Next-state, next-PC and pending-redirect decisions.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    pend_nxt  = pend;
    apply     = 1'b0;
    case (state)
      OFF: state_nxt = RUN;
      RUN: begin
        if (!bus.stall_i) begin
          if (any) begin
            // Redirect squashes the current fetch; no increment.
            pc_nxt = tgt;
            apply  = 1'b1;
          end else if (bus.fetch_ready_i) begin
            pc_nxt = pc + INC;
          end
        end else if (any) begin
          pend_nxt  = tgt;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.stall_i) begin
          // Newest redirect replaces whatever is parked.
          if (any) pend_nxt = tgt;
        end else begin
          // A same-cycle redirect is newer than the parked one.
          pc_nxt    = any ? tgt : pend;
          apply     = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = OFF;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= OFF;
    else      state <= state_nxt;
  end

  // PC, parked redirect and saturating redirect counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc   <= RESET_PC;
      pend <= '0;
      cnt  <= '0;
    end else begin
      pc   <= pc_nxt;
      pend <= pend_nxt;
      if (apply && cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.pc_o          = pc;
  assign bus.fetch_valid_o = (state == RUN);
  assign bus.hold_o        = (state == HOLD);
  assign bus.ce_o          = (state != OFF);
  assign bus.redir_cnt_o   = cnt;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen; a second instance with a 2-bit counter
// shares the same stimulus to exercise counter saturation.
module tb_pc_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  pc_gen_if #(.ADDR_W(32), .NUM_REDIR(3), .CNT_W(16)) if1 ();
  pc_gen_if #(.ADDR_W(32), .NUM_REDIR(3), .CNT_W(2))  if2 ();

  pc_gen #(.CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(if1));
  pc_gen #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(if2));

  assign if2.stall_i       = if1.stall_i;
  assign if2.redir_valid_i = if1.redir_valid_i;
  assign if2.redir_addr_i  = if1.redir_addr_i;
  assign if2.fetch_ready_i = if1.fetch_ready_i;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [31:0] a);
    if1.redir_addr_i[k*32 +: 32] = a;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if1.stall_i = 1'b0; if1.redir_valid_i = '0; if1.redir_addr_i = '0; if1.fetch_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (if1.pc_o !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", if1.pc_o); end
    n_cmp++; if (if1.ce_o !== 1'b0) begin n_bad++; $display("FAIL reset_ce: got %b want 0", if1.ce_o); end
    n_cmp++; if (if1.fetch_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_fv: got %b want 0", if1.fetch_valid_o); end
    n_cmp++; if (if1.hold_o !== 1'b0) begin n_bad++; $display("FAIL reset_hold: got %b want 0", if1.hold_o); end
    n_cmp++; if (if1.redir_cnt_o !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", if1.redir_cnt_o); end
    rst = 1'b1;
    #1;
    n_cmp++; if (if1.ce_o !== 1'b0) begin n_bad++; $display("FAIL release_ce_early: got %b want 0", if1.ce_o); end
    tick();
    n_cmp++; if (if1.ce_o !== 1'b1) begin n_bad++; $display("FAIL first_run_ce: got %b want 1", if1.ce_o); end
    n_cmp++; if (if1.fetch_valid_o !== 1'b1) begin n_bad++; $display("FAIL first_run_fv: got %b want 1", if1.fetch_valid_o); end
    n_cmp++; if (if1.pc_o !== 32'h0) begin n_bad++; $display("FAIL first_run_pc: got %h want 0", if1.pc_o); end
  endtask

  task automatic test_sequential();
    tick();
    n_cmp++; if (if1.pc_o !== 32'h4) begin n_bad++; $display("FAIL seq_pc4: got %h want 4", if1.pc_o); end
    tick();
    n_cmp++; if (if1.pc_o !== 32'h8) begin n_bad++; $display("FAIL seq_pc8: got %h want 8", if1.pc_o); end
    if1.fetch_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (if1.pc_o !== 32'h8 || if1.fetch_valid_o !== 1'b1) begin
        n_bad++; $display("FAIL notready_hold[%0d]: got pc %h fv %b want 8/1", i, if1.pc_o, if1.fetch_valid_o);
      end
    end
    if1.fetch_ready_i = 1'b1;
    tick();
    n_cmp++; if (if1.pc_o !== 32'hC) begin n_bad++; $display("FAIL seq_pc12: got %h want c", if1.pc_o); end
  endtask

  task automatic test_redirect();
    set_ch(1, 32'h100); set_ch(2, 32'h200); if1.redir_valid_i = 3'b110;
    tick();
    n_cmp++; if (if1.pc_o !== 32'h100) begin n_bad++; $display("FAIL redir_prio: got %h want 100", if1.pc_o); end
    n_cmp++; if (if1.redir_cnt_o !== 16'd1) begin n_bad++; $display("FAIL redir_cnt1: got %0d want 1", if1.redir_cnt_o); end
    set_ch(1, 32'h105); if1.redir_valid_i = 3'b010;
    tick();
    n_cmp++; if (if1.pc_o !== 32'h104) begin n_bad++; $display("FAIL redir_align: got %h want 104", if1.pc_o); end
    set_ch(0, 32'h300); set_ch(1, 32'h310); set_ch(2, 32'h320); if1.redir_valid_i = 3'b111;
    tick();
    n_cmp++; if (if1.pc_o !== 32'h300) begin n_bad++; $display("FAIL redir_all: got %h want 300", if1.pc_o); end
    n_cmp++; if (if1.redir_cnt_o !== 16'd3) begin n_bad++; $display("FAIL redir_cnt3: got %0d want 3", if1.redir_cnt_o); end
    if1.redir_valid_i = 3'b000;
    tick();
    n_cmp++; if (if1.pc_o !== 32'h304) begin n_bad++; $display("FAIL post_redir_inc: got %h want 304", if1.pc_o); end
  endtask

  task automatic test_stall_plain();
    if1.stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (if1.pc_o !== 32'h304 || if1.fetch_valid_o !== 1'b1 || if1.hold_o !== 1'b0) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got pc %h fv %b hold %b want 304/1/0", i, if1.pc_o, if1.fetch_valid_o, if1.hold_o);
      end
    end
    if1.stall_i = 1'b0;
    tick();
    n_cmp++; if (if1.pc_o !== 32'h308) begin n_bad++; $display("FAIL stall_release: got %h want 308", if1.pc_o); end
  endtask

  task automatic test_stall_hold();
    if1.stall_i = 1'b1; set_ch(2, 32'h40); if1.redir_valid_i = 3'b100;   // cycle t
    tick();                                                               // t+1
    n_cmp++; if (if1.hold_o !== 1'b1 || if1.fetch_valid_o !== 1'b0 || if1.ce_o !== 1'b1 || if1.pc_o !== 32'h308) begin
      n_bad++; $display("FAIL hold_t1: got hold %b fv %b ce %b pc %h want 1/0/1/308", if1.hold_o, if1.fetch_valid_o, if1.ce_o, if1.pc_o);
    end
    if1.redir_valid_i = 3'b000;
    tick();                                                               // t+2
    n_cmp++; if (if1.hold_o !== 1'b1 || if1.fetch_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL hold_t2: got hold %b fv %b want 1/0", if1.hold_o, if1.fetch_valid_o);
    end
    set_ch(0, 32'h80); if1.redir_valid_i = 3'b001;
    tick();                                                               // t+3
    n_cmp++; if (if1.hold_o !== 1'b1 || if1.fetch_valid_o !== 1'b0 || if1.redir_cnt_o !== 16'd3) begin
      n_bad++; $display("FAIL hold_t3: got hold %b fv %b cnt %0d want 1/0/3", if1.hold_o, if1.fetch_valid_o, if1.redir_cnt_o);
    end
    if1.redir_valid_i = 3'b000;
    tick();                                                               // t+4
    n_cmp++; if (if1.hold_o !== 1'b1 || if1.fetch_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL hold_t4: got hold %b fv %b want 1/0", if1.hold_o, if1.fetch_valid_o);
    end
    if1.stall_i = 1'b0;
    tick();                                                               // t+5
    n_cmp++; if (if1.pc_o !== 32'h80 || if1.hold_o !== 1'b0 || if1.fetch_valid_o !== 1'b1) begin
      n_bad++; $display("FAIL hold_exit: got pc %h hold %b fv %b want 80/0/1", if1.pc_o, if1.hold_o, if1.fetch_valid_o);
    end
    n_cmp++; if (if1.redir_cnt_o !== 16'd4) begin n_bad++; $display("FAIL hold_exit_cnt: got %0d want 4", if1.redir_cnt_o); end
    // New redirect on the exit cycle beats the parked one.
    if1.stall_i = 1'b1; set_ch(1, 32'h500); if1.redir_valid_i = 3'b010;
    tick();
    if1.stall_i = 1'b0; set_ch(2, 32'h600); if1.redir_valid_i = 3'b100;
    tick();
    n_cmp++; if (if1.pc_o !== 32'h600 || if1.redir_cnt_o !== 16'd5) begin
      n_bad++; $display("FAIL hold_exit_new: got pc %h cnt %0d want 600/5", if1.pc_o, if1.redir_cnt_o);
    end
    if1.redir_valid_i = 3'b000;
  endtask

  task automatic test_wrap();
    set_ch(0, 32'hFFFF_FFFC); if1.redir_valid_i = 3'b001;
    tick();
    n_cmp++; if (if1.pc_o !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_setup: got %h want fffffffc", if1.pc_o); end
    if1.redir_valid_i = 3'b000; if1.fetch_ready_i = 1'b1;
    tick();
    n_cmp++; if (if1.pc_o !== 32'h0) begin n_bad++; $display("FAIL wrap: got %h want 0", if1.pc_o); end
  endtask

  task automatic test_reset_mid();
    if1.stall_i = 1'b1; set_ch(0, 32'h700); if1.redir_valid_i = 3'b001;
    tick();
    n_cmp++; if (if1.hold_o !== 1'b1) begin n_bad++; $display("FAIL mid_hold_entry: got %b want 1", if1.hold_o); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (if1.pc_o !== 32'h0 || if1.ce_o !== 1'b0 || if1.fetch_valid_o !== 1'b0 || if1.hold_o !== 1'b0 || if1.redir_cnt_o !== 16'd0) begin
      n_bad++; $display("FAIL async_reset: got pc %h ce %b fv %b hold %b cnt %0d want 0/0/0/0/0",
                        if1.pc_o, if1.ce_o, if1.fetch_valid_o, if1.hold_o, if1.redir_cnt_o);
    end
    if1.stall_i = 1'b0; if1.redir_valid_i = 3'b000; if1.fetch_ready_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (if1.pc_o !== 32'h0 || if1.fetch_valid_o !== 1'b1) begin
      n_bad++; $display("FAIL rerelease: got pc %h fv %b want 0/1", if1.pc_o, if1.fetch_valid_o);
    end
    tick();
    n_cmp++; if (if1.pc_o !== 32'h0 || if1.hold_o !== 1'b0) begin
      n_bad++; $display("FAIL no_stale: got pc %h hold %b want 0/0", if1.pc_o, if1.hold_o);
    end
    if1.fetch_ready_i = 1'b1;
    tick();
    n_cmp++; if (if1.pc_o !== 32'h4) begin n_bad++; $display("FAIL rerelease_inc: got %h want 4", if1.pc_o); end
  endtask

  task automatic test_saturate();
    logic [1:0] exp2 [5];
    exp2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      set_ch(0, 32'h1000 + 32'(i) * 32'h10); if1.redir_valid_i = 3'b001;
      tick();
      n_cmp++; if (if2.redir_cnt_o !== exp2[i]) begin
        n_bad++; $display("FAIL sat_cnt2[%0d]: got %0d want %0d", i, if2.redir_cnt_o, exp2[i]);
      end
      n_cmp++; if (if1.redir_cnt_o !== 16'(i + 1)) begin
        n_bad++; $display("FAIL wide_cnt[%0d]: got %0d want %0d", i, if1.redir_cnt_o, i + 1);
      end
    end
    if1.redir_valid_i = 3'b000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_stall_plain();
    test_stall_hold();
    test_wrap();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator; next generation of the single-channel PC register.
- Feeds the instruction-fetch stage through a valid/ready handshake.
- Arbitrates NUM_REDIR redirect channels by fixed priority: exception, id-stage branch, predictor.
- A redirect that arrives while the pipeline is stalled is held until the stall clears, never dropped; also keeps a saturating redirect counter for perf.

Parameters:
- ADDR_W, 32, PC / address width in bits.
- RESET_VEC, 32'h0, PC after reset; low ALIGN_LSB bits forced to 0.
- INST_BYTES, 4, sequential increment per accepted fetch.
- NUM_REDIR, 3, number of redirect channels; index 0 has highest priority.
- ALIGN_LSB, 1, number of low PC bits forced to zero on every redirect.
- CNT_W, 16, redirect counter width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_i  in  1  pipeline stall from ctrl (stall[0]).
- redir_valid_i  in  NUM_REDIR  per-channel redirect request.
- redir_addr_i  in  NUM_REDIR*ADDR_W  channel k target at bits [k*ADDR_W +: ADDR_W].
- fetch_ready_i  in  1  fetch stage accepts pc_o this cycle.
- pc_o  out  ADDR_W  current fetch address.
- fetch_valid_o  out  1  pc_o is valid for fetch.
- ce_o  out  1  chip enable to instruction memory.
- hold_o  out  1  a deferred redirect is pending.
- redir_cnt_o  out  CNT_W  number of applied redirects, saturating.

Behaviour:
- FSM states:
  - OFF: in reset; ce_o=0, fetch_valid_o=0.
  - RUN: normal fetch.
  - HOLD: redirect latched during stall.
- Reset (rst=0, asynchronous): state=OFF, pc_o=RESET_VEC aligned, ce_o=0, fetch_valid_o=0, hold_o=0, pending register=0, redir_cnt_o=0.
- OFF -> RUN on the first rising edge after rst deasserts: ce_o=1, fetch_valid_o=1, pc_o unchanged (RESET_VEC). First fetch is therefore RESET_VEC, one cycle after release.
- Selection: sel = lowest index k with redir_valid_i[k]=1; tgt = redir_addr_i[k] with low ALIGN_LSB bits cleared; any = |redir_valid_i.
- RUN, stall_i=0, any=1: pc_o<=tgt; fetch_valid_o stays 1. The current pc_o is squashed even if fetch_ready_i=1, and no increment happens.
- RUN, stall_i=0, any=0:
  - fetch_ready_i=1: pc_o<=pc_o+INST_BYTES, modulo 2^ADDR_W (wraps to 0).
  - fetch_ready_i=0: pc_o holds.
- RUN, stall_i=1, any=0: all state holds; fetch_valid_o stays 1 and fetch_ready_i is ignored.
- RUN, stall_i=1, any=1: pending<=tgt; state->HOLD; hold_o=1; fetch_valid_o=0 (registered, next cycle); pc_o holds.
- HOLD, stall_i=1:
  - any=1: pending<=tgt. A newer redirect always overwrites an older pending one.
  - any=0: pending holds.
- HOLD, stall_i=0:
  - any=1: pc_o<=tgt. A same-cycle new redirect beats pending.
  - any=0: pc_o<=pending.
  - In both cases: state->RUN, hold_o=0, fetch_valid_o=1.
- redir_cnt_o increments by 1 on every edge where a redirect is applied to pc_o: RUN with stall_i=0 and any=1, or HOLD exit. Overwrites into pending do not count. Saturates at all-ones.
- ce_o=1 in RUN and HOLD.
- Reset asserted mid-operation: immediate return to OFF values, pending discarded.
- Redirect inputs are ignored in OFF.
- A redirect with all channels asserted takes channel 0 only.

Test Plan:
- Reset release, stall_i=0, fetch_ready_i=1 -> pc_o=0 on first RUN cycle, then 4, 8, 12; ce_o rises one cycle after release.
- fetch_ready_i=0 for 3 cycles at pc_o=8 -> pc_o stays 8, fetch_valid_o=1; fetch_ready_i=1 -> pc_o=12.
- Same cycle redir_valid_i=3'b110, ch1=0x100, ch2=0x200, stall_i=0 -> pc_o=0x100, redir_cnt_o=1; ch1=0x105 -> pc_o=0x104.
- stall_i=1, ch2=0x40 at cycle t, ch0=0x80 at t+2, stall_i=0 at t+4 -> hold_o=1 during t+1..t+4, fetch_valid_o=0 during t+1..t+4, pc_o=0x80 at t+5, redir_cnt_o incremented once.
- pc_o=32'hFFFFFFFC, fetch_ready_i=1 -> pc_o=0; rst pulsed low while in HOLD -> all outputs reset values asynchronously, pc_o=RESET_VEC after release with no stale redirect.
- CNT_W=2, 5 redirects -> redir_cnt_o 1,2,3,3,3.
